// File: rtl/digger_pkg.sv
// Shared definitions for the keyboard/player path: PS/2 scan codes,
// prefix-state and direction enums, and the decoded key-event record.
package digger_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;

  // Frames without any received byte before held arrows are presumed stuck.
  localparam logic [5:0] STUCK_FRAMES = 6'd63;

  typedef enum logic [1:0] {
    PFX_IDLE,
    PFX_EXT,
    PFX_BRK,
    PFX_EXT_BRK
  } pfx_state_t;

  // Also used by player_direction; the encoding doubles as the held-bit index.
  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef struct packed {
    logic [7:0] code;
    logic       is_ext;
    logic       is_break;
  } key_event_t;

  function automatic logic is_arrow(input logic [7:0] code);
    return (code == SC_UP) || (code == SC_DOWN) ||
           (code == SC_LEFT) || (code == SC_RIGHT);
  endfunction

  function automatic dir_t arrow_dir(input logic [7:0] code);
    dir_t d;
    case (code)
      SC_DOWN:  d = DIR_DOWN;
      SC_LEFT:  d = DIR_LEFT;
      SC_RIGHT: d = DIR_RIGHT;
      default:  d = DIR_UP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/scan_prefix_fsm.sv
// Tracks E0/F0 prefixes of the PS/2 byte stream and emits one key_event
// strobe per complete scan code, tagged with its extended/break flags.
//
// state       | meaning
// PFX_IDLE    | no prefix pending
// PFX_EXT     | E0 received
// PFX_BRK     | F0 received (plain release)
// PFX_EXT_BRK | E0 F0 received (extended release)
module scan_prefix_fsm
  import digger_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       kbd_valid,
  input  logic [7:0] kbd_data,
  output logic       key_event_valid,
  output key_event_t key_event
);

  pfx_state_t state_q, state_d;

  // The event is decoded in the same cycle as the final byte so that the
  // held state in the parent lands exactly one cycle after kbd_valid.
  always_comb begin
    state_d            = state_q;
    key_event_valid    = 1'b0;
    key_event.code     = kbd_data;
    key_event.is_ext   = 1'b0;
    key_event.is_break = 1'b0;
    if (kbd_valid) begin
      case (state_q)
        PFX_IDLE: begin
          if (kbd_data == SC_EXT) begin
            state_d = PFX_EXT;
          end else if (kbd_data == SC_BRK) begin
            state_d = PFX_BRK;
          end else begin
            key_event_valid = 1'b1;
          end
        end
        PFX_EXT: begin
          if (kbd_data == SC_BRK) begin
            state_d = PFX_EXT_BRK;
          end else if (kbd_data != SC_EXT) begin
            key_event_valid  = 1'b1;
            key_event.is_ext = 1'b1;
            state_d          = PFX_IDLE;
          end
        end
        PFX_BRK: begin
          key_event_valid    = 1'b1;
          key_event.is_break = 1'b1;
          state_d            = PFX_IDLE;
        end
        default: begin
          key_event_valid    = 1'b1;
          key_event.is_ext   = 1'b1;
          key_event.is_break = 1'b1;
          state_d            = PFX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PFX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/arrow_keys_decoder.sv
// Turns PS/2 scan codes into frame-stable arrow levels and a one-frame fire
// pulse. Optional stuck-key timeout is enabled by ARROW_STUCK_TIMEOUT_EN.
module arrow_keys_decoder
  import digger_pkg::*;
#(
  parameter logic SINGLE_DIR = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       kbd_valid,
  input  logic [7:0] kbd_data,
  output logic       leftArrowPressed,
  output logic       rightArrowPressed,
  output logic       upArrowPressed,
  output logic       downArrowPressed,
  output logic       fireRequest
);

  logic       ev_valid;
  key_event_t ev;
  dir_t       ev_dir;

  logic [3:0] held_q, held_d;
  dir_t       last_q, last_d;
  logic       fire_pend_q, fire_pend_d;
  logic [3:0] dir_out_q, dir_out_d;
  logic       fire_q, fire_d;
  logic [3:0] sel;

  scan_prefix_fsm u_prefix (
    .clk             (clk),
    .rst             (reset),
    .kbd_valid       (kbd_valid),
    .kbd_data        (kbd_data),
    .key_event_valid (ev_valid),
    .key_event       (ev)
  );

  assign ev_dir = arrow_dir(ev.code);

`ifdef ARROW_STUCK_TIMEOUT_EN
  logic [5:0] stuck_cnt_q, stuck_cnt_d;
  logic       stuck_timeout;

  // Down-counts frames since the last byte; any byte reloads it.
  assign stuck_timeout = startOfFrame && !kbd_valid && (stuck_cnt_q == 6'd1);

  always_comb begin
    stuck_cnt_d = stuck_cnt_q;
    if (kbd_valid) begin
      stuck_cnt_d = STUCK_FRAMES;
    end else if (startOfFrame) begin
      stuck_cnt_d = stuck_timeout ? STUCK_FRAMES : stuck_cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stuck_cnt_q <= STUCK_FRAMES;
    end else begin
      stuck_cnt_q <= stuck_cnt_d;
    end
  end
`endif

  always_comb begin
    held_d = held_q;
    last_d = last_q;
    if (ev_valid && ev.is_ext && is_arrow(ev.code)) begin
      if (ev.is_break) begin
        held_d[ev_dir] = 1'b0;
      end else begin
        held_d[ev_dir] = 1'b1;
        last_d         = ev_dir;
      end
    end
`ifdef ARROW_STUCK_TIMEOUT_EN
    if (stuck_timeout) begin
      held_d = '0;
    end
`endif
  end

  // A space arriving on the frame strobe survives the clear and fires next frame.
  always_comb begin
    fire_pend_d = fire_pend_q;
    if (startOfFrame) begin
      fire_pend_d = 1'b0;
    end
    if (ev_valid && !ev.is_ext && !ev.is_break && (ev.code == SC_SPACE)) begin
      fire_pend_d = 1'b1;
    end
  end

  always_comb begin
    sel = '0;
    if (SINGLE_DIR) begin
      if (held_q[last_q]) begin
        sel[last_q] = 1'b1;
      end else if (held_q[DIR_UP]) begin
        sel[DIR_UP] = 1'b1;
      end else if (held_q[DIR_DOWN]) begin
        sel[DIR_DOWN] = 1'b1;
      end else if (held_q[DIR_LEFT]) begin
        sel[DIR_LEFT] = 1'b1;
      end else if (held_q[DIR_RIGHT]) begin
        sel[DIR_RIGHT] = 1'b1;
      end
    end else begin
      sel = held_q;
    end
  end

  // Outputs sample the pre-update held state, so a byte on the strobe lands next frame.
  always_comb begin
    dir_out_d = startOfFrame ? sel : dir_out_q;
    fire_d    = startOfFrame && fire_pend_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q      <= '0;
      last_q      <= DIR_UP;
      fire_pend_q <= 1'b0;
      dir_out_q   <= '0;
      fire_q      <= 1'b0;
    end else begin
      held_q      <= held_d;
      last_q      <= last_d;
      fire_pend_q <= fire_pend_d;
      dir_out_q   <= dir_out_d;
      fire_q      <= fire_d;
    end
  end

  assign upArrowPressed    = dir_out_q[DIR_UP];
  assign downArrowPressed  = dir_out_q[DIR_DOWN];
  assign leftArrowPressed  = dir_out_q[DIR_LEFT];
  assign rightArrowPressed = dir_out_q[DIR_RIGHT];
  assign fireRequest       = fire_q;

endmodule

// File: doc/arrow_keys_decoder.md
# arrow_keys_decoder

Converts the PS/2 scan-code byte stream into the four frame-stable arrow-key levels consumed by the player block (`leftArrowPressed`, `rightArrowPressed`, `upArrowPressed`, `downArrowPressed`), plus a one-frame fire request from the space bar. It sits between the PS/2 byte receiver and the player block. It tracks make/break and extended prefixes, keeps per-key held state, and publishes outputs only at frame boundaries, so movement logic sees one consistent direction per frame.

## Interface
- `SINGLE_DIR`, default 1: when 1, at most one direction output is asserted (last-pressed wins); when 0, raw held levels.
- `clk` input 1: system clock.
- `reset` input 1: reset; asynchronous, active-high.
- `startOfFrame` input 1: one-cycle strobe at each frame start.
- `kbd_valid` input 1: one-cycle strobe; `kbd_data` is valid this cycle.
- `kbd_data` input 8: received scan-code byte.
- `leftArrowPressed` output 1: left arrow held, frame-registered.
- `rightArrowPressed` output 1: right arrow held, frame-registered.
- `upArrowPressed` output 1: up arrow held, frame-registered.
- `downArrowPressed` output 1: down arrow held, frame-registered.
- `fireRequest` output 1: one-cycle pulse on the cycle after a `startOfFrame`, if space was pressed during the previous frame.

## Operation
- Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). Transitions occur only on `kbd_valid`.
- In IDLE:
  - E0 moves to EXT.
  - F0 moves to BRK.
  - 0x29 sets `fire_pend`.
  - Any other byte is ignored.
- In EXT:
  - F0 moves to EXT_BRK.
  - E0 stays in EXT.
  - 0x75, 0x72, 0x6B or 0x74 sets held up, down, left or right respectively, and records that key as `last`. Returns to IDLE.
  - Any other byte returns to IDLE with no change.
- In EXT_BRK: an arrow code clears that key's held bit. Any byte returns to IDLE.
- In BRK: any byte returns to IDLE. Non-extended releases, including space, have no effect.
- Direction select when `SINGLE_DIR`=1:
  - If `last` is still held, output `last`.
  - Otherwise, fixed fallback priority among held keys: up > down > left > right.
  - If nothing is held, all outputs are 0.
- Repeated make of a held key (typematic) re-records `last` and is otherwise idempotent.

## Timing
- Held bits and `last` update on the cycle after the final byte's `kbd_valid`.
- Outputs load the selected value only on `startOfFrame`:
  - Outputs are valid the cycle after the strobe and stable for the whole frame.
  - Press-to-output latency is at most one frame plus one cycle.
- `fireRequest` asserts for exactly one cycle after `startOfFrame` and clears `fire_pend` the same cycle.
  - A space press coinciding with `startOfFrame` is kept pending for the next frame.
  - Multiple presses in one frame produce one pulse.
- `kbd_valid` coinciding with `startOfFrame`: the output samples the pre-update held state. The new byte is seen next frame.
- Reset (asynchronous, any time, including mid-prefix): FSM to IDLE; all held bits, `last`, `fire_pend` and every output set to 0.

## Configuration
- `ARROW_STUCK_TIMEOUT_EN` defined: a 6-bit frame counter resets on every `kbd_valid`. After 63 consecutive frames without a byte, all held bits clear, covering a lost break code.
- Without the macro: there is no counter, and held bits clear only on break codes.

## Structure
- The shared package `digger_pkg` holds:
  - scan-code constants: `SC_EXT`=0xE0, `SC_BRK`=0xF0, `SC_UP`, `SC_DOWN`, `SC_LEFT`, `SC_RIGHT`, `SC_SPACE`;
  - the prefix-state enum;
  - the 2-bit direction enum, shared with `player_direction`.
- One sub-module, `scan_prefix_fsm`, owns the prefix states. It emits a `key_event` strobe with `{code, is_ext, is_break}`.
- The top level holds held, `last`, the select logic and the frame registers.

## Test plan
- E0 75, then `startOfFrame` -> `upArrowPressed`=1 the next cycle, other outputs 0; E0 F0 75, then frame -> all 0.
- Hold left (E0 6B), then press right (E0 74), then frame -> only right=1; release right (E0 F0 74), then frame -> left=1.
- Press 0x29 twice within one frame -> a single one-cycle `fireRequest` after the next `startOfFrame`; no pulse in the following frame.
- Send E0 72 with `kbd_valid` on the same cycle as `startOfFrame` -> down stays 0 this frame and becomes 1 the next frame.
- Send E0, then assert `reset` mid-sequence, then 75 -> no key held; outputs 0 after the next frame.
- With `ARROW_STUCK_TIMEOUT_EN`: hold up, then send 63 frames with no bytes -> up=0 from frame 64. Without the macro, up stays 1.
